// File: rtl/mpc_pkg.sv
// Shared types and constants for the MPC configuration controller.
// Used by mpc_cfg_ctrl (optional feature macro: MPC_CFG_CTRL_TIMEOUT_EN).
package mpc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_ISOLATE = 3'd2,
        ST_SWITCH  = 3'd3,
        ST_SETTLE  = 3'd4
    } mpc_cfg_state_t;

    localparam logic [1:0] MPC_CFG_PEND_OFS   = 2'd0;
    localparam logic [1:0] MPC_CFG_CTRL_OFS   = 2'd1;
    localparam logic [1:0] MPC_CFG_STATUS_OFS = 2'd2;

    localparam int MPC_STATUS_BUSY_BIT    = 0;
    localparam int MPC_STATUS_CFG_LSB     = 4;
    localparam int MPC_STATUS_TIMEOUT_BIT = 8;

    function automatic int mpc_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [31:0] mpc_status_word(input logic busy, input logic [3:0] cfg,
                                                    input logic timeout);
        logic [31:0] w;
        w = 32'h0;
        w[MPC_STATUS_BUSY_BIT] = busy;
        w[MPC_STATUS_CFG_LSB +: 4] = cfg;
        w[MPC_STATUS_TIMEOUT_BIT] = timeout;
        return w;
    endfunction

endpackage

// File: rtl/mpc_cfg_ctrl_if.sv
// Wishbone slave bundle between the user bus and the MPC configuration controller.
interface mpc_cfg_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/mpc_cfg_wb_regs.sv
// Wishbone register window: CFG_PEND, CTRL.APPLY pulse, STATUS readback.
module mpc_cfg_wb_regs
    import mpc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [3:0]  RESET_CFG = 4'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    mpc_cfg_ctrl_if.slave wbs,
    input  logic          busy,
    input  logic [3:0]    active_cfg,
    input  logic          timeout,
    output logic [3:0]    cfg_pend,
    output logic          apply
);

    logic        hit_s;
    logic        acc_s;
    logic        wr_s;
    logic [1:0]  ofs_s;
    logic [31:0] rdata_s;
    logic        ack_r;
    logic [31:0] dat_r;
    logic [3:0]  cfg_pend_r;
    logic        unused_s;

    // A cycle already being acked is never re-accepted, so ack is a single-cycle pulse.
    assign hit_s = (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign acc_s = wbs.wbs_stb_i & wbs.wbs_cyc_i & hit_s & ~ack_r;
    assign ofs_s = wbs.wbs_adr_i[3:2];
    assign wr_s  = acc_s & wbs.wbs_we_i & wbs.wbs_sel_i[0];
    assign apply = wr_s & (ofs_s == MPC_CFG_CTRL_OFS) & wbs.wbs_dat_i[0];

    assign unused_s = ^{wbs.wbs_adr_i[1:0], wbs.wbs_sel_i[3:1], wbs.wbs_dat_i[31:4]};

    // Read mux for the register window.
    always_comb begin
        rdata_s = 32'h0;
        case (ofs_s)
            MPC_CFG_PEND_OFS:   rdata_s = {28'h0, cfg_pend_r};
            MPC_CFG_CTRL_OFS:   rdata_s = 32'h0;
            MPC_CFG_STATUS_OFS: rdata_s = mpc_status_word(busy, active_cfg, timeout);
            default:            rdata_s = 32'h0;
        endcase
    end

    // Ack, registered read data and the pending configuration register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_r      <= 1'b0;
            dat_r      <= 32'h0;
            cfg_pend_r <= RESET_CFG;
        end else begin
            ack_r <= acc_s;
            dat_r <= (acc_s && !wbs.wbs_we_i) ? rdata_s : 32'h0;
            if (wr_s && (ofs_s == MPC_CFG_PEND_OFS)) begin
                cfg_pend_r <= wbs.wbs_dat_i[3:0];
            end else begin
                cfg_pend_r <= cfg_pend_r;
            end
        end
    end

    assign wbs.wbs_ack_o = ack_r;
    assign wbs.wbs_dat_o = dat_r;
    assign cfg_pend      = cfg_pend_r;

endmodule

// File: rtl/mpc_cfg_ctrl.sv
// MPC configuration controller: drain -> isolate pads -> switch -> settle.
// Optional drain abort timer enabled by defining MPC_CFG_CTRL_TIMEOUT_EN.
module mpc_cfg_ctrl
    import mpc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter logic [3:0]  RESET_CFG     = 4'h0,
    parameter int          ISO_CYCLES    = 2,
    parameter int          SETTLE_CYCLES = 8,
    parameter int          DRAIN_TIMEOUT = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    mpc_cfg_ctrl_if.slave wbs,
    input  logic          dn_cyc_i,
    output logic [3:0]    configuration,
    output logic          wb_hold_o,
    output logic          io_oe_gate_o,
    output logic          busy_o
);

`ifdef MPC_CFG_CTRL_TIMEOUT_EN
    localparam int CNT_MAX = mpc_max(mpc_max(ISO_CYCLES, SETTLE_CYCLES), DRAIN_TIMEOUT);
`else
    localparam int CNT_MAX = mpc_max(ISO_CYCLES, SETTLE_CYCLES);
`endif
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    mpc_cfg_state_t state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [3:0] config_r;
    logic [3:0] cfg_pend_s;
    logic       hold_r, gate_r, busy_r;
    logic       apply_s;
    logic       timeout_s;

`ifdef MPC_CFG_CTRL_TIMEOUT_EN
    logic timeout_r;
    logic tmo_set_s;
    assign timeout_s = timeout_r;
`else
    assign timeout_s = 1'b0;
`endif

    mpc_cfg_wb_regs #(
        .BASE_ADDR (BASE_ADDR),
        .RESET_CFG (RESET_CFG)
    ) u_regs (
        .clk        (wb_clk_i),
        .rst_n      (wb_rst_ni),
        .wbs        (wbs),
        .busy       (busy_r),
        .active_cfg (config_r),
        .timeout    (timeout_s),
        .cfg_pend   (cfg_pend_s),
        .apply      (apply_s)
    );

    // Next-state and counter logic; counters load on entry and stop at zero.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
`ifdef MPC_CFG_CTRL_TIMEOUT_EN
        tmo_set_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (apply_s) begin
                    state_s = ST_DRAIN;
`ifdef MPC_CFG_CTRL_TIMEOUT_EN
                    cnt_s = CNT_W'(DRAIN_TIMEOUT - 1);
`else
                    cnt_s = '0;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!dn_cyc_i) begin
                    state_s = ST_ISOLATE;
                    cnt_s   = CNT_W'(ISO_CYCLES - 1);
`ifdef MPC_CFG_CTRL_TIMEOUT_EN
                end else if (cnt_r == '0) begin
                    state_s   = ST_IDLE;
                    tmo_set_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
`else
                end else begin
                    state_s = ST_DRAIN;
                end
`endif
            end
            ST_ISOLATE: begin
                if (cnt_r == '0) begin
                    state_s = ST_SWITCH;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_SWITCH: begin
                state_s = ST_SETTLE;
                cnt_s   = CNT_W'(SETTLE_CYCLES - 1);
            end
            ST_SETTLE: begin
                if (cnt_r == '0) begin
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // State register; outputs are decoded from the next state so they align with it.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            config_r <= RESET_CFG;
            hold_r   <= 1'b0;
            gate_r   <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            config_r <= (state_r == ST_SWITCH) ? cfg_pend_s : config_r;
            hold_r   <= (state_s != ST_IDLE);
            busy_r   <= (state_s != ST_IDLE);
            gate_r   <= !((state_s == ST_ISOLATE) || (state_s == ST_SWITCH) ||
                          (state_s == ST_SETTLE));
        end
    end

`ifdef MPC_CFG_CTRL_TIMEOUT_EN
    // Sticky drain-abort flag, cleared only by an APPLY that is actually taken.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            timeout_r <= 1'b0;
        end else if (tmo_set_s) begin
            timeout_r <= 1'b1;
        end else if (apply_s && (state_r == ST_IDLE)) begin
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= timeout_r;
        end
    end
`endif

    assign configuration = config_r;
    assign wb_hold_o     = hold_r;
    assign io_oe_gate_o  = gate_r;
    assign busy_o        = busy_r;

endmodule
